// File: rtl/pipe_stall_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_stall_ctrl_if
// Data-memory request/acknowledge handshake between the pipeline sequencer
// (master) and the data-memory side (slave).
//
// Handshake: the master raises mem_req_o whenever the EX/MEM register holds a
// load or store (mem_access_i) and keeps it high until the cycle in which
// mem_ack_i is seen high. A transfer completes in exactly the cycle where
// mem_req_o and mem_ack_i are both high, and that can be the first request
// cycle. mem_ack_i is meaningless while mem_req_o is low and is ignored then.
//
// Signals
//   mem_access_i  EX/MEM holds a memory instruction   (slave -> master)
//   mem_ack_i     data memory finished current access (slave -> master)
//   mem_req_o     data memory request                 (master -> slave)
// -----------------------------------------------------------------------------
interface pipe_stall_ctrl_if;
  logic mem_access_i;
  logic mem_ack_i;
  logic mem_req_o;

  modport master (
    input  mem_access_i,
    input  mem_ack_i,
    output mem_req_o
  );

  modport slave (
    output mem_access_i,
    output mem_ack_i,
    input  mem_req_o
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_stall_ctrl
// Central sequencer for a 5-stage pipeline. It merges the hazard unit's
// load-use stall and branch-taken indications with a multi-cycle data-memory
// handshake in MEM. It drives the per-stage pipeline-register write enables,
// the IF/ID flush and the ID/EX bubble. It also handles run/halt sequencing
// from start_i, a sticky memory-timeout trap and a saturating stall counter.
//
// Parameters
//   TMO_W  width of the memory-wait counter (trap after 2**TMO_W-1 waits)
//   CNT_W  width of the stall-cycle performance counter
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-low reset
//   start_i        run enable; low holds the pipeline
//   hdu_stall_i    load-use stall from the hazard unit
//   hdu_taken_i    branch taken in ID
//   mem            memory handshake (master modport)
//   pc_we_o .. memwb_we_o  pipeline-register write enables
//   ifid_flush_o   load a NOP into IF/ID
//   idex_bubble_o  load a NOP into ID/EX
//   busy_o         sequencer is in RUN or MWAIT
//   timeout_o      sticky: the memory ack never arrived
//   stall_cnt_o    stall cycles since reset, saturating
//   state_o        current sequencer state (debug observation)
// -----------------------------------------------------------------------------
module pipe_stall_ctrl #(
  parameter int TMO_W = 8,
  parameter int CNT_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 hdu_stall_i,
  input  logic                 hdu_taken_i,
  pipe_stall_ctrl_if.master    mem,
  output logic                 pc_we_o,
  output logic                 ifid_we_o,
  output logic                 idex_we_o,
  output logic                 exmem_we_o,
  output logic                 memwb_we_o,
  output logic                 ifid_flush_o,
  output logic                 idex_bubble_o,
  output logic                 busy_o,
  output logic                 timeout_o,
  output logic [CNT_W-1:0]     stall_cnt_o,
  output logic [1:0]           state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_MWAIT = 2'd2,
    S_ERROR = 2'd3
  } state_t;

  localparam logic [TMO_W-1:0] WAIT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t             state_q, state_d;
  logic [TMO_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   stall_cnt_q;
  logic               active;
  logic               mem_stall;
  logic               stall_inc;

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    timeout_d     = timeout_q;
    active        = 1'b0;
    mem_stall     = 1'b0;
    mem.mem_req_o = 1'b0;
    pc_we_o       = 1'b0;
    ifid_we_o     = 1'b0;
    idex_we_o     = 1'b0;
    exmem_we_o    = 1'b0;
    memwb_we_o    = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_RUN;
      end

      S_RUN, S_MWAIT: begin
        active        = 1'b1;
        mem.mem_req_o = mem.mem_access_i;
        // A same-cycle ack completes the access without any freeze.
        mem_stall     = mem.mem_access_i & ~mem.mem_ack_i;

        if (mem_stall) begin
          // Full freeze. An outstanding access always drains, so start_i
          // is not consulted until the ack arrives.
          if (state_q == S_RUN) begin
            state_d    = S_MWAIT;
            wait_cnt_d = '0;
          end else if (wait_cnt_q == WAIT_MAX) begin
            state_d   = S_ERROR;
            timeout_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end else begin
          idex_we_o  = 1'b1;
          exmem_we_o = 1'b1;
          memwb_we_o = 1'b1;
          if (hdu_stall_i) begin
            // Load-use: hold PC and IF/ID, insert a bubble; a taken branch
            // reported alongside is not acted upon this cycle.
            idex_bubble_o = 1'b1;
          end else begin
            pc_we_o      = 1'b1;
            ifid_we_o    = 1'b1;
            ifid_flush_o = hdu_taken_i;
          end
          wait_cnt_d = '0;
          state_d    = start_i ? S_RUN : S_IDLE;
        end
      end

      S_ERROR: begin
        // Trap state: everything held low, left only through reset.
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign stall_inc   = active & (mem_stall | hdu_stall_i);
  assign busy_o      = active;
  assign timeout_o   = timeout_q;
  assign stall_cnt_o = stall_cnt_q;
  assign state_o     = state_q;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
    end else if (stall_inc && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_stall_ctrl
// Directed bench for pipe_stall_ctrl (TMO_W=3, CNT_W=4). The driver applies one
// input vector per cycle and pushes the hand-computed expected outputs into
// exp_q; the monitor pops one entry per cycle on the falling edge and compares.
// Entry layout: {check, ctl[9:0], state[1:0], stall_cnt[3:0]} where ctl is
// {req, pc_we, ifid_we, idex_we, exmem_we, memwb_we, flush, bubble, busy, timeout}.
// -----------------------------------------------------------------------------
module tb_pipe_stall_ctrl;

  localparam int TMO_W = 3;
  localparam int CNT_W = 4;

  localparam logic [9:0] E_IDLE = 10'b0_00000_00_0_0;
  localparam logic [9:0] E_RUN  = 10'b0_11111_00_1_0;
  localparam logic [9:0] E_RUNR = 10'b1_11111_00_1_0;
  localparam logic [9:0] E_FRZ  = 10'b1_00000_00_1_0;
  localparam logic [9:0] E_HDU  = 10'b0_00111_01_1_0;
  localparam logic [9:0] E_TKN  = 10'b0_11111_10_1_0;
  localparam logic [9:0] E_TKNR = 10'b1_11111_10_1_0;
  localparam logic [9:0] E_ERR  = 10'b0_00000_00_0_1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_MWAIT = 2'd2;
  localparam logic [1:0] ST_ERROR = 2'd3;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT
  // ---------------------------------------------------------------------------
  logic             clk_i = 1'b0;
  logic             rst_i = 1'b0;
  logic             start_i = 1'b0;
  logic             hdu_stall_i = 1'b0;
  logic             hdu_taken_i = 1'b0;
  logic             pc_we_o, ifid_we_o, idex_we_o, exmem_we_o, memwb_we_o;
  logic             ifid_flush_o, idex_bubble_o, busy_o, timeout_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [1:0]       state_o;

  pipe_stall_ctrl_if mem_if ();

  always #5 clk_i = ~clk_i;

  pipe_stall_ctrl #(.TMO_W(TMO_W), .CNT_W(CNT_W)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .hdu_stall_i   (hdu_stall_i),
    .hdu_taken_i   (hdu_taken_i),
    .mem           (mem_if),
    .pc_we_o       (pc_we_o),
    .ifid_we_o     (ifid_we_o),
    .idex_we_o     (idex_we_o),
    .exmem_we_o    (exmem_we_o),
    .memwb_we_o    (memwb_we_o),
    .ifid_flush_o  (ifid_flush_o),
    .idex_bubble_o (idex_bubble_o),
    .busy_o        (busy_o),
    .timeout_o     (timeout_o),
    .stall_cnt_o   (stall_cnt_o),
    .state_o       (state_o)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [16:0]      exp_q[$];
  string            name_q[$];
  logic [CNT_W-1:0] exp_stall = '0;
  int               checks = 0;
  int               failures = 0;

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  task automatic step(input string nm, input logic rs, input logic st,
                      input logic hs, input logic tk, input logic ma,
                      input logic ak, input logic chk,
                      input logic [9:0] ctl, input logic [1:0] stt);
    @(posedge clk_i);
    #1;
    rst_i               = rs;
    start_i             = st;
    hdu_stall_i         = hs;
    hdu_taken_i         = tk;
    mem_if.mem_access_i = ma;
    mem_if.mem_ack_i    = ak;
    if (!rs) exp_stall = '0;
    exp_q.push_back({chk, ctl, stt, exp_stall});
    name_q.push_back(nm);
    // A busy cycle with PC held is a stall cycle; the counter saturates.
    if (rs && ctl[1] && !ctl[8] && (exp_stall != 4'hF)) exp_stall = exp_stall + 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  initial begin : monitor
    logic [16:0] e;
    logic [15:0] act;
    string       nm;
    forever begin
      @(negedge clk_i);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        nm  = name_q.pop_front();
        act = {mem_if.mem_req_o, pc_we_o, ifid_we_o, idex_we_o, exmem_we_o,
               memwb_we_o, ifid_flush_o, idex_bubble_o, busy_o, timeout_o,
               state_o, stall_cnt_o};
        if (e[16]) begin
          checks++;
          if (act !== e[15:0]) begin
            failures++;
            $display("FAIL %s: got ctl=%b state=%0d stall=%0d, expected ctl=%b state=%0d stall=%0d",
                     nm, act[15:6], act[5:4], act[3:0], e[15:6], e[5:4], e[3:0]);
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin : stimulus
    mem_if.mem_access_i = 1'b0;
    mem_if.mem_ack_i    = 1'b0;

    //    name            rs st hs tk ma ak chk ctl     state
    step("reset_a",       0, 1, 1, 1, 1, 1, 1, E_IDLE, ST_IDLE);
    step("reset_b",       0, 0, 0, 0, 0, 0, 1, E_IDLE, ST_IDLE);
    for (int i = 0; i < 5; i++)
      step("idle_hold",   1, 0, 1, 1, 1, 0, 1, E_IDLE, ST_IDLE);
    step("start_edge",    1, 1, 0, 0, 0, 0, 1, E_IDLE, ST_IDLE);
    step("run_first",     1, 1, 0, 0, 0, 0, 1, E_RUN,  ST_RUN);

    // Three-cycle memory wait then ack.
    step("mwait_run",     1, 1, 0, 0, 1, 0, 1, E_FRZ,  ST_RUN);
    step("mwait_1",       1, 1, 0, 0, 1, 0, 1, E_FRZ,  ST_MWAIT);
    step("mwait_2",       1, 1, 0, 0, 1, 0, 1, E_FRZ,  ST_MWAIT);
    step("mwait_ack",     1, 1, 0, 0, 1, 1, 1, E_RUNR, ST_MWAIT);
    step("mwait_after",   1, 1, 0, 0, 0, 0, 1, E_RUN,  ST_RUN);

    // Zero-wait ack and stray ack.
    step("zero_wait",     1, 1, 0, 0, 1, 1, 1, E_RUNR, ST_RUN);
    step("zero_wait_nx",  1, 1, 0, 0, 0, 0, 1, E_RUN,  ST_RUN);
    step("stray_ack",     1, 1, 0, 0, 0, 1, 1, E_RUN,  ST_RUN);

    // Hazard priorities.
    step("hdu_and_taken", 1, 1, 1, 1, 0, 0, 1, E_HDU,  ST_RUN);
    step("hdu_only",      1, 1, 1, 0, 0, 0, 1, E_HDU,  ST_RUN);
    step("taken_only",    1, 1, 0, 1, 0, 0, 1, E_TKN,  ST_RUN);
    step("mem_over_hdu",  1, 1, 1, 1, 1, 0, 1, E_FRZ,  ST_RUN);
    step("ack_taken",     1, 1, 0, 1, 1, 1, 1, E_TKNR, ST_MWAIT);
    step("after_ack_tk",  1, 1, 0, 0, 0, 0, 1, E_RUN,  ST_RUN);

    // start_i falls in RUN.
    step("stop_in_run",   1, 0, 0, 0, 0, 0, 1, E_RUN,  ST_RUN);
    step("stopped",       1, 0, 0, 0, 0, 0, 1, E_IDLE, ST_IDLE);

    // start_i falls in MWAIT: the access drains, then IDLE.
    step("restart",       1, 1, 0, 0, 0, 0, 1, E_IDLE, ST_IDLE);
    step("drain_run",     1, 1, 0, 0, 1, 0, 1, E_FRZ,  ST_RUN);
    step("drain_w1",      1, 0, 0, 0, 1, 0, 1, E_FRZ,  ST_MWAIT);
    step("drain_w2",      1, 0, 0, 0, 1, 0, 1, E_FRZ,  ST_MWAIT);
    step("drain_ack",     1, 0, 0, 0, 1, 1, 1, E_RUNR, ST_MWAIT);
    step("drain_idle",    1, 0, 0, 0, 0, 0, 1, E_IDLE, ST_IDLE);

    // Stall counter saturation.
    step("sat_start",     1, 1, 0, 0, 0, 0, 1, E_IDLE, ST_IDLE);
    for (int i = 0; i < 10; i++)
      step("sat_hdu",     1, 1, 1, 0, 0, 0, 1, E_HDU,  ST_RUN);
    step("sat_hold",      1, 1, 0, 0, 0, 0, 1, E_RUN,  ST_RUN);

    // Memory timeout with TMO_W=3.
    step("tmo_run",       1, 1, 0, 0, 1, 0, 1, E_FRZ,  ST_RUN);
    for (int i = 0; i < 7; i++)
      step("tmo_wait",    1, 1, 0, 0, 1, 0, 1, E_FRZ,  ST_MWAIT);
    step("tmo_edge",      1, 1, 0, 0, 1, 0, 0, E_FRZ,  ST_MWAIT);
    for (int i = 0; i < 4; i++)
      step("tmo_error",   1, 1, 1, 1, 1, 1, 1, E_ERR,  ST_ERROR);
    step("tmo_reset",     0, 1, 0, 0, 0, 0, 1, E_IDLE, ST_IDLE);
    step("post_reset",    1, 0, 0, 0, 0, 0, 1, E_IDLE, ST_IDLE);

    repeat (3) @(negedge clk_i);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
